candy_vend_param: RTL and testbench

- Parametrised coin-operated vending controller; successor to the fixed-price candy FSM.
- Accumulates credit from a 2-bit coin code against a configurable price.
- Issues a vend request through a valid/ready handshake.
- Returns refunds (cancel or inactivity timeout), and optionally overpay change, through a second valid/ready handshake.
- Sits between the coin-acceptor decoder and the dispenser/change-hopper drivers.

---
 rtl/candy_vend_param_if.sv | 31 +++
 rtl/candy_vend_param.sv | 164 ++++++++++++++++
 tb/tb_candy_vend_param.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/candy_vend_param_if.sv
// Handshake bundle between the vending controller and its output drivers.
// The controller side (master) drives the vend request and change amount;
// the dispenser/hopper side (slave) answers with the ready strobes.
interface candy_vend_param_if #(
   parameter int CREDIT_W = 6
);
   logic                vend_valid;
   logic                vend_ready;
   logic                out;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amt;
   logic                change_ready;

   modport master (
      output vend_valid,
      output out,
      output change_valid,
      output change_amt,
      input  vend_ready,
      input  change_ready
   );

   modport slave (
      input  vend_valid,
      input  out,
      input  change_valid,
      input  change_amt,
      output vend_ready,
      output change_ready
   );
endinterface

// File: rtl/candy_vend_param.sv
// Parametrised coin-operated vending controller.
// Accumulates credit from a 2-bit coin code, requests a vend when the price
// is reached, and returns credit on cancel or inactivity timeout.
// Build option: define CANDY_VEND_CHANGE_EN to return any overpay remainder
// as change right after a vend; otherwise the remainder stays as credit.
module candy_vend_param #(
   parameter int CREDIT_W    = 6,
   parameter int PRICE       = 15,
   parameter int COIN1_VAL   = 5,
   parameter int COIN2_VAL   = 10,
   parameter int COIN3_VAL   = 25,
   parameter int TIMEOUT_CYC = 1000,
   parameter int TO_W        = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          in,
   input  logic                cancel,
   candy_vend_param_if.master  bus,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic [2:0]          pre_s,
   output logic [2:0]          next_s
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCUM  = 3'd1,
      S_VEND   = 3'd2,
      S_CHANGE = 3'd3,
      S_REFUND = 3'd4
   } state_t;

   // One extra bit on the adder exposes overflow of the credit register.
   localparam int                  SUM_W   = CREDIT_W + 1;
   localparam logic [SUM_W-1:0]    COIN1_C = SUM_W'(COIN1_VAL);
   localparam logic [SUM_W-1:0]    COIN2_C = SUM_W'(COIN2_VAL);
   localparam logic [SUM_W-1:0]    COIN3_C = SUM_W'(COIN3_VAL);
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam bit                  TO_EN   = (TIMEOUT_CYC != 0);
   localparam logic [TO_W-1:0]     TO_LAST = TO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic                out_q, out_d;
   logic                rej_q, rej_d;

   logic [SUM_W-1:0]    coin_val;
   logic [SUM_W-1:0]    sum;
   logic [CREDIT_W-1:0] rem;
   logic                coin_present;
   logic                coin_fits;
   logic                coin_acc;
   logic                timeout_hit;

   // Decode the coin code into its credit value.
   always_comb begin
      coin_val = '0;
      unique case (in)
         2'b01:   coin_val = COIN1_C;
         2'b10:   coin_val = COIN2_C;
         2'b11:   coin_val = COIN3_C;
         default: coin_val = '0;
      endcase
   end

   assign coin_present = (in != 2'b00);
   assign sum          = {1'b0, credit_q} + coin_val;
   assign coin_fits    = ~sum[CREDIT_W];
   assign rem          = credit_q - PRICE_C;
   assign timeout_hit  = TO_EN && (to_q == TO_LAST);

   // Next-state, credit update and pulse generation.
   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      coin_acc = 1'b0;
      rej_d    = 1'b0;
      out_d    = 1'b0;
      unique case (state_q)
         S_IDLE, S_ACCUM: begin
            if (cancel) begin
               // Cancel beats a simultaneous coin; in IDLE there is nothing to refund.
               rej_d = coin_present;
               if (state_q == S_ACCUM) state_d = S_REFUND;
            end else if (coin_present && coin_fits) begin
               coin_acc = 1'b1;
               credit_d = sum[CREDIT_W-1:0];
               // The price test uses the updated credit so one coin can reach VEND.
               state_d  = (sum[CREDIT_W-1:0] >= PRICE_C) ? S_VEND : S_ACCUM;
            end else begin
               rej_d = coin_present;
               if (state_q == S_ACCUM && timeout_hit) state_d = S_REFUND;
            end
         end
         S_VEND: begin
            rej_d = coin_present;
            if (bus.vend_ready) begin
               credit_d = rem;
               out_d    = 1'b1;
               if (rem == '0) begin
                  state_d = S_IDLE;
               end else begin
`ifdef CANDY_VEND_CHANGE_EN
                  state_d = S_CHANGE;
`else
                  state_d = S_ACCUM;
`endif
               end
            end
         end
         S_CHANGE, S_REFUND: begin
            rej_d = coin_present;
            if (bus.change_ready) begin
               credit_d = '0;
               state_d  = S_IDLE;
            end
         end
         default: begin
            // Unused encodings recover to IDLE with credit discarded.
            rej_d    = coin_present;
            credit_d = '0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // Inactivity counter: runs only while staying in ACCUM without a credited coin.
   always_comb begin
      to_d = '0;
      if (TO_EN && state_q == S_ACCUM && state_d == S_ACCUM && !coin_acc)
         to_d = to_q + TO_W'(1);
   end

   // State, credit, counter and pulse registers.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         credit_q <= '0;
         to_q     <= '0;
         out_q    <= 1'b0;
         rej_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         to_q     <= to_d;
         out_q    <= out_d;
         rej_q    <= rej_d;
      end
   end

   assign bus.vend_valid   = (state_q == S_VEND);
   assign bus.change_valid = (state_q == S_CHANGE) || (state_q == S_REFUND);
   assign bus.change_amt   = bus.change_valid ? credit_q : '0;
   assign bus.out          = out_q;
   assign coin_reject      = rej_q;
   assign credit           = credit_q;
   assign pre_s            = state_q;
   assign next_s           = state_d;

endmodule

// File: tb/tb_candy_vend_param.sv
// Self-checking bench for candy_vend_param (TIMEOUT_CYC shortened to 8).
// Vectors hold the inputs for one cycle and the outputs expected right after
// the following rising edge; expectations are queued on drive and compared
// once the edge has produced them.
`timescale 1ns/1ps
module tb_candy_vend_param;
   localparam int CW = 6;
`ifdef CANDY_VEND_CHANGE_EN
   localparam bit CHG = 1'b1;
`else
   localparam bit CHG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    in;
   logic          cancel;
   logic          coin_reject;
   logic [CW-1:0] credit;
   logic [2:0]    pre_s;
   logic [2:0]    next_s;

   candy_vend_param_if #(.CREDIT_W(CW)) bus ();

   candy_vend_param #(
      .CREDIT_W(CW), .PRICE(15), .COIN1_VAL(5), .COIN2_VAL(10), .COIN3_VAL(25),
      .TIMEOUT_CYC(8), .TO_W(4)
   ) dut (
      .clk(clk), .reset(reset), .in(in), .cancel(cancel), .bus(bus),
      .coin_reject(coin_reject), .credit(credit), .pre_s(pre_s), .next_s(next_s)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [1:0]    coin;
      logic          cancel;
      logic          vrdy;
      logic          crdy;
      logic [CW-1:0] credit;
      logic [2:0]    st;
      logic          vv;
      logic          outp;
      logic          rej;
      logic          cv;
      logic [CW-1:0] amt;
   } vec_t;

   int   n_cmp  = 0;
   int   n_fail = 0;
   vec_t exp_q[$];
   vec_t tbl[$];

   function automatic vec_t mk(string name, int coin, bit cn, bit vrdy, bit crdy, int cr, int st,
                               bit vv, bit outp, bit rej, bit cv, int amt);
      vec_t v;
      v.name = name;   v.coin = 2'(coin); v.cancel = cn;  v.vrdy = vrdy; v.crdy = crdy;
      v.credit = CW'(cr); v.st = 3'(st); v.vv = vv; v.outp = outp; v.rej = rej;
      v.cv = cv; v.amt = CW'(amt);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic compare_next();
      vec_t e;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      check({e.name, ".credit"},       32'(credit),           32'(e.credit));
      check({e.name, ".pre_s"},        32'(pre_s),            32'(e.st));
      check({e.name, ".vend_valid"},   32'(bus.vend_valid),   32'(e.vv));
      check({e.name, ".out"},          32'(bus.out),          32'(e.outp));
      check({e.name, ".coin_reject"},  32'(coin_reject),      32'(e.rej));
      check({e.name, ".change_valid"}, 32'(bus.change_valid), 32'(e.cv));
      check({e.name, ".change_amt"},   32'(bus.change_amt),   32'(e.amt));
   endtask

   task automatic step(input vec_t v);
      @(negedge clk);
      in               = v.coin;
      cancel           = v.cancel;
      bus.vend_ready   = v.vrdy;
      bus.change_ready = v.crdy;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      compare_next();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; in = 2'b11; cancel = 1'b0;
      bus.vend_ready = 1'b0; bus.change_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("rst.credit",       32'(credit),           32'd0);
      check("rst.pre_s",        32'(pre_s),            32'd0);
      check("rst.vend_valid",   32'(bus.vend_valid),   32'd0);
      check("rst.out",          32'(bus.out),          32'd0);
      check("rst.coin_reject",  32'(coin_reject),      32'd0);
      check("rst.change_valid", 32'(bus.change_valid), 32'd0);
      check("rst.change_amt",   32'(bus.change_amt),   32'd0);
      @(negedge clk);
      in = 2'b00; reset = 1'b1;

      //                name        coin cn vr cr credit st vv out rej cv amt
      tbl.push_back(mk("ex_c1",     1, 0, 1, 0,  5, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk("ex_c2",     2, 0, 1, 0, 15, 2, 1, 0, 0, 0, 0));
      tbl.push_back(mk("ex_vend",   0, 0, 1, 0,  0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk("ex_idle",   0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("op_c3",     3, 0, 0, 0, 25, 2, 1, 0, 0, 0, 0));
      tbl.push_back(mk("bp_coin",   3, 0, 0, 0, 25, 2, 1, 0, 1, 0, 0));
      tbl.push_back(mk("bp_hold",   0, 0, 0, 0, 25, 2, 1, 0, 0, 0, 0));
      tbl.push_back(mk("op_vend",   0, 0, 1, 0, 10, CHG ? 3 : 1, 0, 1, 0, CHG, CHG ? 10 : 0));
      tbl.push_back(mk("op_hold",   0, 1, 0, 0, 10, CHG ? 3 : 4, 0, 0, 0, 1, 10));
      tbl.push_back(mk("op_ret",    0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("cn_c1",     1, 0, 0, 0,  5, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk("cn_cancel", 2, 1, 0, 0,  5, 4, 0, 0, 1, 1, 5));
      tbl.push_back(mk("cn_wait0",  0, 0, 0, 0,  5, 4, 0, 0, 0, 1, 5));
      tbl.push_back(mk("cn_wait1",  0, 0, 0, 0,  5, 4, 0, 0, 0, 1, 5));
      tbl.push_back(mk("cn_wait2",  0, 0, 0, 0,  5, 4, 0, 0, 0, 1, 5));
      tbl.push_back(mk("cn_ret",    0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
`ifndef CANDY_VEND_CHANGE_EN
      // Repeated overpay builds the carried credit up until a coin overflows.
      tbl.push_back(mk("ov_c1",     3, 0, 1, 0, 25, 2, 1, 0, 0, 0, 0));
      tbl.push_back(mk("ov_v1",     0, 0, 1, 0, 10, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk("ov_c2",     3, 0, 1, 0, 35, 2, 1, 0, 0, 0, 0));
      tbl.push_back(mk("ov_v2",     0, 0, 1, 0, 20, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk("ov_c3",     3, 0, 1, 0, 45, 2, 1, 0, 0, 0, 0));
      tbl.push_back(mk("ov_v3",     0, 0, 1, 0, 30, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk("ov_c4",     3, 0, 1, 0, 55, 2, 1, 0, 0, 0, 0));
      tbl.push_back(mk("ov_v4",     0, 0, 1, 0, 40, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk("ov_rej",    3, 0, 1, 0, 40, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk("ov_c5",     2, 0, 1, 0, 50, 2, 1, 0, 0, 0, 0));
      tbl.push_back(mk("ov_v5",     0, 0, 1, 0, 35, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk("ov_cancel", 0, 1, 1, 0, 35, 4, 0, 0, 0, 1, 35));
      tbl.push_back(mk("ov_ret",    0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
`endif

      foreach (tbl[i]) step(tbl[i]);

      // Timeout: REFUND lands exactly 8 edges after the accepting edge.
      step(mk("to_coin", 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
      for (int i = 0; i < 7; i++)
         step(mk($sformatf("to_wait%0d", i), 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
      check("to_next_s", 32'(next_s), 32'd4);
      step(mk("to_refund", 0, 0, 0, 0, 5, 4, 0, 0, 0, 1, 5));
      step(mk("to_ret",    0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

      // Asynchronous reset while a return is pending.
`ifdef CANDY_VEND_CHANGE_EN
      step(mk("ar_coin", 3, 0, 1, 0, 25, 2, 1, 0, 0, 0, 0));
      step(mk("ar_chg",  0, 0, 1, 0, 10, 3, 0, 1, 0, 1, 10));
`else
      step(mk("ar_coin", 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
      step(mk("ar_ref",  0, 1, 0, 0, 5, 4, 0, 0, 0, 1, 5));
`endif
      #2;
      in = 2'b00; cancel = 1'b0; bus.vend_ready = 1'b0; bus.change_ready = 1'b0;
      reset = 1'b0;
      #1;
      check("ar.change_valid", 32'(bus.change_valid), 32'd0);
      check("ar.credit",       32'(credit),           32'd0);
      check("ar.pre_s",        32'(pre_s),            32'd0);
      check("ar.change_amt",   32'(bus.change_amt),   32'd0);
      @(negedge clk);
      reset = 1'b1;
      step(mk("ar_after", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
